// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: round-robin share of one Avalon-style bus between fetch (I) and load/store (D) masters
module mips_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      i_address,
  input  logic             i_read,
  output logic             i_waitrequest,
  output logic [31:0]      i_readdata,
  input  logic [31:0]      d_address,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [31:0]      d_writedata,
  input  logic [3:0]       d_byteenable,
  output logic             d_waitrequest,
  output logic [31:0]      d_readdata,
  output logic [31:0]      m_address,
  output logic             m_read,
  output logic             m_write,
  output logic [31:0]      m_writedata,
  output logic [3:0]       m_byteenable,
  input  logic             m_waitrequest,
  input  logic [31:0]      m_readdata,
  output logic             grant_d,
  output logic             bus_error,
  output logic [CNT_W-1:0] txn_count
);
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, ABORT} state_t;
  state_t r_state, w_next;
  logic r_last_d;
  logic r_err;
  logic [SW-1:0] r_stall;
  logic [CNT_W-1:0] r_count;
  logic w_req_i, w_req_d, w_gnt_d, w_granted, w_req_x, w_done, w_timeout;
  assign w_req_i   = i_read;
  assign w_req_d   = d_read | d_write;
  assign w_gnt_d   = r_state == GRANT_D;
  assign w_granted = (r_state == GRANT_I) | w_gnt_d;
  assign w_req_x   = w_gnt_d ? w_req_d : w_req_i;
  assign w_done    = w_granted & w_req_x & ~m_waitrequest;
  assign w_timeout = w_granted & w_req_x & m_waitrequest & (r_stall == SW'(TIMEOUT_CYCLES - 1));
  assign grant_d   = w_gnt_d;
  assign bus_error = r_err;
  assign txn_count = r_count;
  // state register; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  // arbitration: on a tie the master not served last wins; grants end on completion, drop or timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:             w_next = (w_req_i & w_req_d) ? (r_last_d ? GRANT_I : GRANT_D) :
                                 w_req_d ? GRANT_D : w_req_i ? GRANT_I : IDLE;
      GRANT_I, GRANT_D: w_next = w_timeout ? ABORT : (w_done | ~w_req_x) ? IDLE : r_state;
      default:          w_next = IDLE;
    endcase
  end
  // last_served is updated on entry to ABORT so ABORT can tell which master it is releasing
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_last_d <= 1'b0;
      r_err    <= 1'b0;
      r_stall  <= '0;
      r_count  <= '0;
    end else begin
      r_stall  <= (r_state == IDLE) ? '0 : (w_granted & m_waitrequest) ? r_stall + SW'(1) : r_stall;
      r_last_d <= (w_done | w_timeout) ? w_gnt_d : r_last_d;
      r_err    <= r_err | w_timeout;
      r_count  <= w_done ? r_count + CNT_W'(1) : r_count;
    end
  // bus mux: the granted master is wired through, the other is held off with zero data
  always_comb begin
    m_address     = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_writedata   = '0;
    m_byteenable  = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    i_readdata    = '0;
    d_readdata    = '0;
    if (r_state == GRANT_I) begin
      m_address     = i_address;
      m_read        = i_read;
      m_byteenable  = 4'hF;
      i_waitrequest = m_waitrequest;
      i_readdata    = m_readdata;
    end
    if (w_gnt_d) begin
      m_address     = d_address;
      m_read        = d_read & ~d_write;
      m_write       = d_write;
      m_writedata   = d_writedata;
      m_byteenable  = d_byteenable;
      d_waitrequest = m_waitrequest;
      d_readdata    = m_readdata;
    end
    if (r_state == ABORT) begin
      i_waitrequest = r_last_d;
      d_waitrequest = ~r_last_d;
    end
  end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: random masters and slave checked every cycle against a transaction-level model
module tb_mips_bus_arbiter;
  localparam int TO = 8;
  localparam int CW = 8;
  logic clk, reset;
  logic [31:0] i_address, i_readdata, d_address, d_writedata, d_readdata, m_address, m_writedata, m_readdata;
  logic i_read, i_waitrequest, d_read, d_write, d_waitrequest, m_read, m_write, m_waitrequest, grant_d, bus_error;
  logic [3:0] d_byteenable, m_byteenable;
  logic [CW-1:0] txn_count;
  int n_chk, n_fail;
  // model: owner -1 none, 0 fetch, 1 data; abrt marks the one-cycle release after a timeout
  int owner, stall, cnt;
  bit abrt, abrt_d, last_d, err;
  bit seen_iw, seen_dw;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .grant_d(grant_d), .bus_error(bus_error), .txn_count(txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; stall = 0; cnt = 0; abrt = 0; abrt_d = 0; last_d = 0; err = 0;
  endtask

  task automatic check_step();
    logic [31:0] ea, ew, eir, edr;
    logic er, ewr, eiw, edw;
    logic [3:0] ebe;
    bit rq_i, rq_d, rq;
    if (!reset) model_reset();
    ea = 0; ew = 0; eir = 0; edr = 0; er = 0; ewr = 0; eiw = 1; edw = 1; ebe = 0;
    if (owner == 0) begin
      ea = i_address; er = i_read; ebe = 4'hF; eiw = m_waitrequest; eir = m_readdata;
    end else if (owner == 1) begin
      ea = d_address; er = d_read && !d_write; ewr = d_write; ew = d_writedata; ebe = d_byteenable;
      edw = m_waitrequest; edr = m_readdata;
    end else if (abrt) begin
      eiw = abrt_d; edw = !abrt_d;
    end
    check("m_address", m_address, ea);
    check("m_read", 32'(m_read), 32'(er));
    check("m_write", 32'(m_write), 32'(ewr));
    check("m_writedata", m_writedata, ew);
    check("m_byteenable", 32'(m_byteenable), 32'(ebe));
    check("i_waitrequest", 32'(i_waitrequest), 32'(eiw));
    check("d_waitrequest", 32'(d_waitrequest), 32'(edw));
    check("i_readdata", i_readdata, eir);
    check("d_readdata", d_readdata, edr);
    check("grant_d", 32'(grant_d), 32'(owner == 1));
    check("bus_error", 32'(bus_error), 32'(err));
    check("txn_count", 32'(txn_count), 32'(cnt));
    seen_iw = eiw; seen_dw = edw;
    if (!reset) return;
    rq_i = i_read; rq_d = d_read || d_write;
    if (abrt) abrt = 0;
    else if (owner < 0) begin
      owner = (rq_i && rq_d) ? (last_d ? 0 : 1) : rq_d ? 1 : rq_i ? 0 : -1;
      stall = 0;
    end else begin
      rq = (owner == 1) ? rq_d : rq_i;
      if (!rq) owner = -1;
      else if (!m_waitrequest) begin
        cnt = (cnt + 1) % (1 << CW); last_d = (owner == 1); owner = -1;
      end else begin
        stall++;
        if (stall == TO) begin
          abrt = 1; abrt_d = (owner == 1); last_d = (owner == 1); err = 1; owner = -1;
        end
      end
    end
  endtask

  // md: 0 random, 1 stuck slave, 2 both always requesting zero-wait, 3 fetch-only zero-wait,
  //     4 quiet, 5 directed first cycle after reset, 6 hold reset
  task automatic drive(input int md);
    bit go_i, go_d;
    int k;
    reset = (md != 6);
    m_readdata = $urandom;
    m_waitrequest = (md == 1) ? 1'b1 : (md == 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
    if (md == 5) begin
      i_read = 1; i_address = 32'hBFC00000;
      d_read = 0; d_write = 1; d_address = 32'h1000; d_byteenable = 4'b0011; d_writedata = $urandom;
      return;
    end
    go_i = (md == 0) ? ($urandom_range(0, 2) != 0) : (md inside {1, 2, 3});
    go_d = (md == 0) ? ($urandom_range(0, 2) != 0) : (md inside {1, 2});
    if (md == 4 || md == 6) begin
      i_read = 0; d_read = 0; d_write = 0;
      return;
    end
    if (!i_read || !seen_iw) begin
      i_read = go_i; i_address = $urandom;
    end else if (md == 0 && $urandom_range(0, 63) == 0) i_read = 0;
    if (!(d_read || d_write) || !seen_dw) begin
      k = go_d ? $urandom_range(1, 3) : 0;
      d_read = k[0]; d_write = k[1];
      d_address = $urandom; d_writedata = $urandom; d_byteenable = 4'($urandom);
    end else if (md == 0 && $urandom_range(0, 63) == 0) begin
      d_read = 0; d_write = 0;
    end
  endtask

  task automatic tick(input int md, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1 drive(md);
      #3 check_step();
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 0; i_read = 0; d_read = 0; d_write = 0; m_waitrequest = 0;
    i_address = 0; d_address = 0; d_writedata = 0; d_byteenable = 0; m_readdata = 0;
    seen_iw = 1; seen_dw = 1;
    model_reset();
    tick(6, 2);
    tick(5, 1);
    tick(2, 12);
    tick(0, 3000);
    tick(1, 60);
    tick(0, 500);
    tick(6, 2);
    tick(4, 10);
    tick(3, 700);
    tick(0, 300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
